// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning HI/LO; divider present only with `define MULDIV_DIVIDE_EN
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       MDOp,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [2:0] OP_MULT = 3'd0;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    logic [1:0]         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opd;      // multiplicand (mult) or divisor (div) magnitude
    logic [2*WIDTH-1:0] r_acc;      // product accumulator or {remainder, quotient}
    logic               r_neg_lo;   // negate product (mult) or quotient (div) in FIX

    logic               w_idle_start;
    logic               w_start_iter;
    logic               w_signed_op;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [2*WIDTH-1:0] w_acc_step;
    logic [2*WIDTH-1:0] w_mul_res;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Signed ops run on magnitudes; the result sign is restored in FIX.
    assign w_idle_start = start & ~r_busy;
    assign w_signed_op  = (MDOp == OP_MULT) | (MDOp == OP_DIV);
    assign w_sign_a     = w_signed_op & inA[WIDTH-1];
    assign w_sign_b     = w_signed_op & inB[WIDTH-1];
    assign w_mag_a      = w_sign_a ? -inA : inA;
    assign w_mag_b      = w_sign_b ? -inB : inB;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_mul_res  = r_neg_lo ? -r_acc : r_acc;

`ifdef MULDIV_DIVIDE_EN
    logic               r_is_div;
    logic               r_neg_hi;   // remainder takes the dividend's sign
    logic               w_is_div_req;
    logic               w_b_zero;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_div_step;
    logic [WIDTH-1:0]   w_quo_res;
    logic [WIDTH-1:0]   w_rem_res;

    assign w_is_div_req = (MDOp[2:1] == 2'b01);
    assign w_b_zero     = (inB == '0);
    assign w_start_iter = w_idle_start & ~MDOp[2];

    // Restoring step: a zero divisor never borrows, giving all-ones quotient and the dividend as remainder.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_borrow   = (w_rem_sh < {1'b0, r_opd});
    assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opd;
    assign w_div_step = w_borrow ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                 : {w_diff, r_acc[WIDTH-2:0], 1'b1};
    assign w_acc_step = r_is_div ? w_div_step : w_mul_step;

    assign w_quo_res  = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem_res  = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_res_hi   = r_is_div ? w_rem_res : w_mul_res[2*WIDTH-1:WIDTH];
    assign w_res_lo   = r_is_div ? w_quo_res : w_mul_res[WIDTH-1:0];
`else
    assign w_start_iter = w_idle_start & (MDOp[2:1] == 2'b00);
    assign w_acc_step   = w_mul_step;
    assign w_res_hi     = w_mul_res[2*WIDTH-1:WIDTH];
    assign w_res_lo     = w_mul_res[WIDTH-1:0];
`endif

    // Control FSM, iteration datapath and HI/LO write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opd    <= '0;
            r_acc    <= '0;
            r_neg_lo <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_iter) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
                        r_opd    <= w_mag_a;
                        r_neg_lo <= w_sign_a ^ w_sign_b;
`ifdef MULDIV_DIVIDE_EN
                        r_is_div <= w_is_div_req;
                        r_neg_hi <= w_sign_a;
                        if (w_is_div_req) begin
                            r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
                            r_opd    <= w_mag_b;
                            r_neg_lo <= (w_sign_a ^ w_sign_b) & ~w_b_zero;
                        end
`endif
                    end else if (w_idle_start && (MDOp == OP_MTHI)) begin
                        r_hi <= inA;
                    end else if (w_idle_start && (MDOp == OP_MTLO)) begin
                        r_lo <= inA;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
